mpc_mul_share_arb: RTL and testbench

Round-robin scheduler that shares one pipelined `mpc_mul_mul_21s_7ns_29_4_1` multiplier (21-bit signed × 7-bit unsigned → 29-bit signed, 4 clock-enabled stages) among `NUM_REQ` requesters in the MPC datapath. It accepts at most one operand pair per cycle and tags each issued operation with its requester index. It returns each product on a single tagged response port. Response backpressure freezes the multiplier through its `ce` input, so no result is ever dropped.

---
 rtl/mpc_mul_share_arb.sv | 138 +++++++++++++
 tb/tb_mpc_mul_share_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_mul_share_arb.sv
// mpc_mul_share_arb
//
// Shares one pipelined multiplier (21-bit signed x 7-bit unsigned -> 29-bit
// signed, MUL_LAT clock-enabled stages) among NUM_REQ requesters. Each cycle
// at most one operand pair is granted round-robin and sent to the
// multiplier. A tag pipeline runs alongside the multiplier stages. It carries
// the requester index of each operation so the product can be returned on a
// single tagged response port. If the consumer holds back a valid response,
// the whole pipeline freezes through mul_ce, so no product is lost.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   req_valid[N]       : per-requester operand valid
//   req_ready[N]       : per-requester accept (one-hot or zero)
//   req_din0[21*N]     : packed signed operand A, requester i at [21i+20:21i]
//   req_din1[7*N]      : packed unsigned operand B, requester i at [7i+6:7i]
//   mul_ce             : multiplier clock enable
//   mul_din0, mul_din1 : operands to the multiplier
//   mul_dout           : multiplier product
//   rsp_valid/ready    : response handshake
//   rsp_id, rsp_data   : requester index and product of the response
//   busy               : at least one operation in flight

module mpc_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [21*NUM_REQ-1:0] req_din0,
    input  logic [7*NUM_REQ-1:0] req_din1,
    output logic                 mul_ce,
    output logic [20:0]          mul_din0,
    output logic [6:0]           mul_din1,
    input  logic [28:0]          mul_dout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [28:0]          rsp_data,
    output logic                 busy
);

    // Tag pipeline: one valid bit and one requester id per multiplier stage.
    logic [MUL_LAT-1:0] vld_reg;
    logic [ID_W-1:0]    id_reg [MUL_LAT];
    logic [ID_W-1:0]    rr_ptr_reg;

    logic [20:0] din0_arr [NUM_REQ];
    logic [6:0]  din1_arr [NUM_REQ];

    logic            stall;
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [ID_W-1:0] rr_ptr_next;

    // Unpack the flat operand buses into per-requester arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign din0_arr[gi] = req_din0[21*gi +: 21];
            assign din1_arr[gi] = req_din1[7*gi +: 7];
        end
    endgenerate

    // The pipeline freezes only while a real product is waiting at the output.
    // Bubbles never stall.
    assign stall  = vld_reg[MUL_LAT-1] & ~rsp_ready;
    // During reset the tag stages may still show stale contents for one cycle.
    // Forcing ce high keeps the multiplier enabled, which is what the
    // reset state requires.
    assign mul_ce = reset | ~stall;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!stall && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(idx);
                end
            end
        end
    end

    assign accept = grant_any;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Operands go to zero when nothing is granted. The bubble is then marked
    // invalid in the tag stage, so its product is never presented.
    assign mul_din0 = accept ? din0_arr[grant_idx] : 21'd0;
    assign mul_din1 = accept ? din1_arr[grant_idx] : 7'd0;

    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_reg    <= '0;
            rr_ptr_reg <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                id_reg[s] <= '0;
            end
        end else begin
            if (mul_ce) begin
                vld_reg   <= {vld_reg[MUL_LAT-2:0], accept};
                id_reg[0] <= grant_idx;
                for (int s = 1; s < MUL_LAT; s++) begin
                    id_reg[s] <= id_reg[s-1];
                end
            end
            if (accept) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign rsp_valid = vld_reg[MUL_LAT-1];
    assign rsp_id    = id_reg[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign busy      = |vld_reg;

endmodule

// File: tb/tb_mpc_mul_share_arb.sv
module tb_mpc_mul_share_arb;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [21*N-1:0]   req_din0;
    logic [7*N-1:0]    req_din1;
    logic              mul_ce;
    logic [20:0]       mul_din0;
    logic [6:0]        mul_din1;
    logic [28:0]       mul_dout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [28:0]       rsp_data;
    logic              busy;

    logic signed [20:0] a_op [N];
    logic [6:0]         b_op [N];

    always #5 clk = ~clk;

    mpc_mul_share_arb #(.NUM_REQ(N), .ID_W(IW), .MUL_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always_comb begin
        req_din0 = '0;
        req_din1 = '0;
        for (int i = 0; i < N; i++) begin
            req_din0[21*i +: 21] = a_op[i];
            req_din1[7*i +: 7]   = b_op[i];
        end
    end

    // Behavioural multiplier: L clock-enabled stages, product formed in stage 0.
    logic signed [28:0] mpipe [L];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= $signed(mul_din0) * $signed({1'b0, mul_din1});
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_dout = mpipe[L-1];

    // Reference model. Every accepted operation is time-stamped with the
    // count of enabled cycles. It becomes due after L enabled cycles.
    typedef struct {
        int     id;
        longint prod;
        longint t;
    } exp_t;

    exp_t         q[$];
    longint       ce_cnt;
    int           rr_m;
    int           errors;
    int           checks;
    logic [N-1:0] granted_last;

    task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit head_due();
        return (q.size() > 0) && (ce_cnt - q[0].t == longint'(L));
    endfunction

    // Monitor: compares the response port against the head of the queue.
    task automatic monitor_rsp(input bit hv);
        chk("busy", busy, q.size() > 0);
        chk("rsp_valid", rsp_valid, hv);
        if (hv && rsp_valid) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", $signed(rsp_data), q[0].prod);
            $display("rsp id=%0d data=%0d", rsp_id, $signed(rsp_data));
        end
        if (hv && rsp_ready) void'(q.pop_front());
    endtask

    // Predictor: round-robin grant from the model pointer, and stall state.
    task automatic predict_issue(input bit hv);
        bit           stall;
        int           g;
        int           idx;
        logic [N-1:0] exp_ready;
        stall = hv && !rsp_ready;
        chk("mul_ce", mul_ce, !stall);
        g = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        granted_last = exp_ready;
        if (g >= 0) begin
            q.push_back('{g, longint'(a_op[g]) * longint'(b_op[g]), ce_cnt});
            rr_m = (g + 1) % N;
            $display("issue id=%0d a=%0d b=%0d", g, a_op[g], b_op[g]);
        end
        if (!stall) ce_cnt++;
    endtask

    always @(negedge clk) begin
        bit hv;
        if (reset) begin
            chk("req_ready_rst", req_ready, 0);
            chk("mul_ce_rst", mul_ce, 1);
            q.delete();
            rr_m = 0;
            granted_last = '0;
        end else begin
            hv = head_due();
            monitor_rsp(hv);
            predict_issue(hv);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (granted_last[i]) req_valid[i] = 1'b0;
        end
    endtask

    task automatic post(input int i, input int a, input int b);
        if (!req_valid[i]) begin
            a_op[i]      = 21'(a);
            b_op[i]      = 7'(b);
            req_valid[i] = 1'b1;
        end
    endtask

    initial begin
        int  waited;
        errors       = 0;
        checks       = 0;
        ce_cnt       = 0;
        rr_m         = 0;
        granted_last = '0;
        reset        = 1'b1;
        req_valid    = '0;
        rsp_ready    = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_op[i]  = '0;
            b_op[i]  = '0;
            mpipe[i] = '0;
        end
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single request from requester 2.
        post(2, -1000, 100);
        repeat (8) step();

        // Operand extremes.
        post(0, -1048576, 127);
        post(1, 1048575, 127);
        post(3, 12345, 0);
        repeat (10) step();

        // Fairness: all requesters keep requesting.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) post(i, int'(21'($urandom)), int'(7'($urandom)));
            step();
        end
        repeat (10) step();

        // Backpressure once the first of three products is presented.
        post(0, 111, 3);
        post(1, -222, 5);
        post(2, 333, 7);
        waited = 0;
        while (!head_due() && waited < 20) begin
            step();
            waited++;
        end
        chk("bp_wait_timeout", waited < 20, 1);
        rsp_ready = 1'b0;
        post(3, 44, 4);
        repeat (5) step();
        rsp_ready = 1'b1;
        repeat (10) step();

        // Reset while two operations are in flight.
        post(1, 500, 9);
        post(3, -600, 11);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        for (int i = 0; i < N; i++) post(i, 1000 + i, i + 1);
        repeat (10) step();

        // Bubble insertion: alternating requests.
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) post(0, -7 * c, c);
            step();
        end
        repeat (8) step();

        // Randomized traffic with random backpressure and one reset.
        for (int c = 0; c < 600; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) post(i, int'(21'($urandom)), int'(7'($urandom)));
            end
            reset = (c == 300);
            step();
        end
        reset = 1'b0;

        // Drain.
        rsp_ready = 1'b1;
        req_valid = '0;
        waited = 0;
        while (q.size() > 0 && waited < 40) begin
            step();
            waited++;
        end
        chk("drain_left", q.size(), 0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
